// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
// Shared definitions for the pipeline hazard controller.
//   - stall vector bit positions (STALL_PC .. STALL_WB)
//   - stall masks for ID, EX and MEM hazards
//   - controller FSM state encodings
//   - hazard_t decision record and resolve_hazard(), the priority resolver
//     that turns the raw stage requests into a stall vector and a jump-accept
//     decision.
// Optional feature macro used by files importing this package:
//   PIPE_CTRL_WDOG_EN
package pipe_ctrl_pkg;

    // Bit positions inside the 6-bit stall vector; 1 means the stage is held.
    localparam int STALL_PC  = 0;
    localparam int STALL_IF  = 1;
    localparam int STALL_ID  = 2;
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;

    // A hazard in stage X freezes X and everything upstream of it. The first
    // register that is not held receives a bubble.
    localparam logic [5:0] STALL_NONE     = 6'b000000;
    localparam logic [5:0] STALL_ID_MASK  = 6'b000111;
    localparam logic [5:0] STALL_EX_MASK  = 6'b001111;
    localparam logic [5:0] STALL_MEM_MASK = 6'b011111;

    // Controller FSM encodings.
    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_STALLED = 1'b1;

    // Outcome of one cycle of hazard arbitration.
    typedef struct packed {
        logic [5:0] stall;
        logic       accept;
    } hazard_t;

    // Priority, highest first: MEM stall, EX stall, jump, ID stall.
    // A jump is only taken once per EX instruction, which is what jump_done
    // tracks. When a jump wins, the ID stall is dropped because the
    // instruction in ID is about to be flushed anyway.
    function automatic hazard_t resolve_hazard(
        input logic req_mem,
        input logic req_ex,
        input logic req_id,
        input logic req_jump,
        input logic jump_done
    );
        hazard_t res;
        res.stall  = STALL_NONE;
        res.accept = 1'b0;
        if (req_mem) begin
            res.stall = STALL_MEM_MASK;
        end else if (req_ex) begin
            res.stall = STALL_EX_MASK;
        end else if (req_jump && !jump_done) begin
            res.accept = 1'b1;
        end else if (req_id) begin
            res.stall = STALL_ID_MASK;
        end
        return res;
    endfunction

endpackage

// File: rtl/pipe_ctrl_wdog.sv
// pipe_ctrl_wdog
// Stall watchdog: counts consecutive cycles the controller spends in the
// STALLED state. When the count reaches LIMIT, a sticky timeout flag is set on
// the following edge. Only a reset clears the flag.
// Ports:
//   clk           in  core clock
//   rst           in  synchronous active-high reset
//   stalled       in  controller FSM is in STALLED
//   stall_timeout out sticky watchdog error
// Instantiated by pipe_ctrl only when PIPE_CTRL_WDOG_EN is defined.
module pipe_ctrl_wdog #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic stalled,
    output logic stall_timeout
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] stall_run;

    // The run length restarts whenever the controller leaves STALLED. It
    // saturates at LIMIT so it cannot wrap back and look healthy. Once the
    // count reaches LIMIT, the error flag latches and stays set until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_run     <= '0;
            stall_timeout <= 1'b0;
        end else begin
            if (!stalled) begin
                stall_run <= '0;
            end else if (stall_run != CW'(LIMIT)) begin
                stall_run <= stall_run + CW'(1);
            end
            if (stall_run == CW'(LIMIT)) begin
                stall_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl
// Central hazard controller for the five-stage core. It arbitrates stall
// requests from ID/EX/MEM and taken-branch requests from EX. It drives the
// per-stage stall vector and the IF/ID flush with its redirect PC. It also
// keeps stall and flush performance counters.
// Ports:
//   clk           in   core clock
//   rst           in   synchronous active-high reset
//   stallreq_id   in   load-use hazard in ID
//   stallreq_ex   in   multi-cycle op busy in EX
//   stallreq_mem  in   memory bus wait in MEM
//   jump_req_ex   in   EX resolved a taken branch/jump
//   jump_addr_ex  in   redirect target [31:0]
//   stall         out  [5:0] pc,if,id,ex,mem,wb hold bits
//   flush         out  kill IF/ID and load PC this cycle
//   flush_pc      out  [31:0] redirect target, 0 when flush is low
//   stall_cycles  out  [31:0] cycles with any stall bit set
//   flush_count   out  [31:0] accepted jumps
//   stall_timeout out  sticky watchdog error
// Configuration: define PIPE_CTRL_WDOG_EN to build the stall watchdog
// (parameter WDOG_LIMIT). Without the macro, stall_timeout is tied to 0.
module pipe_ctrl #(
    parameter int WDOG_LIMIT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic        jump_req_ex,
    input  logic [31:0] jump_addr_ex,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] flush_pc,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count,
    output logic        stall_timeout
);

    import pipe_ctrl_pkg::*;

    hazard_t     hz;
    logic        jump_accept;
    logic        jump_done;
    logic [0:0]  state;
    logic [0:0]  state_next;
    logic [31:0] stall_cycles_q;
    logic [31:0] flush_count_q;
    logic        timeout_raw;

    // Zero-latency arbitration of this cycle's requests. Reset overrides
    // everything, so a request that arrives during reset has no effect.
    always_comb begin
        hz          = resolve_hazard(stallreq_mem, stallreq_ex, stallreq_id,
                                     jump_req_ex, jump_done);
        stall       = STALL_NONE;
        flush       = 1'b0;
        flush_pc    = 32'd0;
        jump_accept = 1'b0;
        if (!rst) begin
            stall       = hz.stall;
            jump_accept = hz.accept;
            flush       = hz.accept;
            flush_pc    = hz.accept ? jump_addr_ex : 32'd0;
        end
    end

    // FSM next state: the controller is STALLED whenever any stage is held.
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN:     if (stall != STALL_NONE) state_next = ST_STALLED;
            ST_STALLED: if (stall == STALL_NONE) state_next = ST_RUN;
            default:    state_next = ST_RUN;
        endcase
    end

    // While a MEM/EX stall blocks a jump, EX stays frozen and keeps its
    // request up, so no separate pending flag is needed. jump_done prevents a
    // second flush for the same EX instruction. It stays set while EX is held
    // and clears on the first cycle EX advances without a new acceptance.
    // Both counters wrap naturally at 32 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            jump_done      <= 1'b0;
            state          <= ST_RUN;
            stall_cycles_q <= 32'd0;
            flush_count_q  <= 32'd0;
        end else begin
            if (jump_accept) begin
                jump_done <= 1'b1;
            end else if (!stall[STALL_EX]) begin
                jump_done <= 1'b0;
            end
            state <= state_next;
            if (stall != STALL_NONE) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (jump_accept) begin
                flush_count_q <= flush_count_q + 32'd1;
            end
        end
    end

`ifdef PIPE_CTRL_WDOG_EN
    pipe_ctrl_wdog #(
        .LIMIT(WDOG_LIMIT)
    ) u_wdog (
        .clk          (clk),
        .rst          (rst),
        .stalled      (state == ST_STALLED),
        .stall_timeout(timeout_raw)
    );
`else
    logic wdog_unused;
    assign wdog_unused = ^{state, (WDOG_LIMIT != 0)};
    assign timeout_raw = 1'b0;
`endif

    // The registered outputs also read as zero while reset is held, so every
    // output shows its reset value during reset, not only after the edge.
    assign stall_cycles  = rst ? 32'd0 : stall_cycles_q;
    assign flush_count   = rst ? 32'd0 : flush_count_q;
    assign stall_timeout = rst ? 1'b0  : timeout_raw;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl
// Self-checking bench for pipe_ctrl. Each stimulus cycle pushes its expected
// combinational outputs onto a queue. The queue entry is popped and compared
// on the falling edge of the same cycle. The counters and the watchdog flag
// are compared against a small reference model that the bench advances from
// its own expected values. Build with PIPE_CTRL_WDOG_EN to exercise the
// watchdog (WDOG_LIMIT = 8).
module tb_pipe_ctrl;

    localparam int LIMIT = 8;

    typedef struct {
        logic        mem;
        logic        ex;
        logic        id;
        logic        jreq;
        logic [31:0] addr;
        logic [5:0]  exp_stall;
        logic        exp_flush;
        logic [31:0] exp_pc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stallreq_id = 1'b0;
    logic        stallreq_ex = 1'b0;
    logic        stallreq_mem = 1'b0;
    logic        jump_req_ex = 1'b0;
    logic [31:0] jump_addr_ex = 32'd0;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
    logic        stall_timeout;

    int total = 0;
    int bad = 0;
    vec_t sb_q[$];
    vec_t vecs[9];

    // Reference model of the registered state, advanced once per cycle.
    logic [31:0] m_sc = 32'd0;
    logic [31:0] m_fc = 32'd0;
    int          m_cnt = 0;
    logic        m_state = 1'b0;
    logic        m_to = 1'b0;
`ifdef PIPE_CTRL_WDOG_EN
    localparam logic WDOG_ON = 1'b1;
`else
    localparam logic WDOG_ON = 1'b0;
`endif

    pipe_ctrl #(
        .WDOG_LIMIT(LIMIT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .jump_req_ex  (jump_req_ex),
        .jump_addr_ex (jump_addr_ex),
        .stall        (stall),
        .flush        (flush),
        .flush_pc     (flush_pc),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count),
        .stall_timeout(stall_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of requests just after the rising edge and queue the
    // outputs the controller must produce for them.
    task automatic applyStimulus(input vec_t v);
        @(posedge clk);
        #1;
        rst          = 1'b0;
        stallreq_mem = v.mem;
        stallreq_ex  = v.ex;
        stallreq_id  = v.id;
        jump_req_ex  = v.jreq;
        jump_addr_ex = v.addr;
        sb_q.push_back(v);
    endtask

    // Compare on the falling edge. Then advance the model as the next rising
    // edge will.
    task automatic checkOutput();
        vec_t e;
        @(negedge clk);
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb_q.pop_front();
        chk("stall", {26'd0, stall}, {26'd0, e.exp_stall});
        chk("flush", {31'd0, flush}, {31'd0, e.exp_flush});
        chk("flush_pc", flush_pc, e.exp_pc);
        chk("stall_cycles", stall_cycles, m_sc);
        chk("flush_count", flush_count, m_fc);
        chk("stall_timeout", {31'd0, stall_timeout}, {31'd0, m_to});
        m_to = WDOG_ON && (m_to || (m_cnt == LIMIT));
        if (!m_state) m_cnt = 0;
        else if (m_cnt != LIMIT) m_cnt = m_cnt + 1;
        m_state = (e.exp_stall != 6'd0);
        if (e.exp_stall != 6'd0) m_sc = m_sc + 32'd1;
        if (e.exp_flush) m_fc = m_fc + 32'd1;
    endtask

    task automatic step(input logic mem, input logic ex, input logic id, input logic jreq,
                        input logic [31:0] addr, input logic [5:0] es, input logic ef,
                        input logic [31:0] ep);
        vec_t v;
        v.mem = mem; v.ex = ex; v.id = id; v.jreq = jreq; v.addr = addr;
        v.exp_stall = es; v.exp_flush = ef; v.exp_pc = ep;
        applyStimulus(v);
        checkOutput();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 32'd0, 6'b000000, 0, 32'd0);
    endtask

    // Hold reset for one rising edge while the given requests are active.
    // Every output must read its reset value the whole time.
    task automatic doReset(input logic mem, input logic jreq, input logic [31:0] addr);
        @(posedge clk);
        #1;
        rst          = 1'b1;
        stallreq_mem = mem;
        stallreq_ex  = 1'b0;
        stallreq_id  = 1'b0;
        jump_req_ex  = jreq;
        jump_addr_ex = addr;
        @(negedge clk);
        chk("rst_stall", {26'd0, stall}, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_flush_pc", flush_pc, 32'd0);
        chk("rst_stall_cycles", stall_cycles, 32'd0);
        chk("rst_flush_count", flush_count, 32'd0);
        chk("rst_stall_timeout", {31'd0, stall_timeout}, 32'd0);
        m_sc = 32'd0; m_fc = 32'd0; m_cnt = 0; m_state = 1'b0; m_to = 1'b0;
    endtask

    initial begin
        $display("[TB] pipe_ctrl bench start");
        vecs[0] = '{0, 0, 0, 0, 32'h0,        6'b000000, 0, 32'h0};
        vecs[1] = '{0, 0, 1, 0, 32'h0,        6'b000111, 0, 32'h0};
        vecs[2] = '{0, 1, 0, 0, 32'h0,        6'b001111, 0, 32'h0};
        vecs[3] = '{1, 0, 0, 0, 32'h0,        6'b011111, 0, 32'h0};
        vecs[4] = '{1, 1, 1, 1, 32'h44,       6'b011111, 0, 32'h0};
        vecs[5] = '{0, 1, 1, 1, 32'h48,       6'b001111, 0, 32'h0};
        vecs[6] = '{0, 0, 1, 1, 32'h100,      6'b000000, 1, 32'h100};
        vecs[7] = '{0, 0, 0, 1, 32'hDEADBEEC, 6'b000000, 1, 32'hDEADBEEC};
        vecs[8] = '{1, 1, 0, 0, 32'h0,        6'b011111, 0, 32'h0};

        doReset(0, 0, 32'd0);

        // Single ID stall right after reset, then stall_cycles reads 1.
        step(0, 0, 1, 0, 32'd0, 6'b000111, 0, 32'd0);
        idle();

        // Table: each vector is followed by an idle cycle so jump_done settles.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i]);
            checkOutput();
            idle();
        end

        // Jump blocked by MEM for 3 cycles, then taken exactly once.
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 32'h200, 6'b011111, 0, 32'd0);
        step(0, 0, 0, 1, 32'h200, 6'b000000, 1, 32'h200);
        // Same EX instruction still requesting: no second flush, ID stall applies.
        step(0, 0, 1, 1, 32'h200, 6'b000111, 0, 32'd0);
        idle();

        // jump_done survives a MEM stall because EX is still frozen.
        step(0, 0, 0, 1, 32'h300, 6'b000000, 1, 32'h300);
        step(1, 0, 0, 1, 32'h300, 6'b011111, 0, 32'd0);
        step(0, 0, 0, 1, 32'h300, 6'b000000, 0, 32'd0);
        idle();

        // EX+MEM, MEM drops, then EX drops.
        step(1, 1, 0, 0, 32'd0, 6'b011111, 0, 32'd0);
        step(0, 1, 0, 0, 32'd0, 6'b001111, 0, 32'd0);
        step(0, 0, 0, 0, 32'd0, 6'b000000, 0, 32'd0);

        // Reset while a MEM-blocked jump is pending: the jump is discarded.
        step(1, 0, 0, 1, 32'h400, 6'b011111, 0, 32'd0);
        doReset(1, 1, 32'h400);
        idle();
        idle();

        // Long MEM stall for the watchdog, then requests drop.
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 32'd0, 6'b011111, 0, 32'd0);
        idle();
        chk("wdog_sticky", {31'd0, stall_timeout}, {31'd0, WDOG_ON});
        idle();
        doReset(0, 0, 32'd0);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
